// File: rtl/wb_ram_pipe.sv
// Pipelined single-port Wishbone RAM slave: byte selects, 1..4 cycle read latency, abort on cyc drop.
// Define WB_RAM_ERR_EN to answer out-of-range addresses with err instead of aliasing them.
module wb_ram_pipe #(
   parameter int SIZE       = 'h800,
   parameter int DATA_WIDTH = 16,
   parameter int ADR_WIDTH  = 16,
   parameter int LATENCY    = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cyc_i,
   input  logic                    stb_i,
   input  logic                    we_i,
   input  logic [ADR_WIDTH-1:0]    adr_i,
   input  logic [DATA_WIDTH/8-1:0] sel_i,
   input  logic [DATA_WIDTH-1:0]   dat_i,
   output logic [DATA_WIDTH-1:0]   dat_o,
   output logic                    ack_o,
   output logic                    err_o,
   output logic                    stall_o
);

   localparam int IDX_W = $clog2(SIZE);
   localparam int NB    = DATA_WIDTH / 8;
   localparam int LAST  = LATENCY - 1;

   typedef struct packed {
      logic                  valid;
      logic                  is_err;
      logic                  is_rd;
      logic [DATA_WIDTH-1:0] data;
   } resp_t;

   logic [DATA_WIDTH-1:0] mem_q [SIZE];
   resp_t                 pipe_q [LATENCY];
   resp_t                 pipe_d [LATENCY];
   logic                  accept;
   logic                  oor;
   logic [IDX_W-1:0]      idx;

   assign accept  = cyc_i & stb_i;
   assign idx     = adr_i[IDX_W-1:0];
   assign stall_o = 1'b0;

`ifdef WB_RAM_ERR_EN
   assign oor   = (adr_i >> IDX_W) != '0;
   assign err_o = pipe_q[LAST].valid & pipe_q[LAST].is_err;
`else
   logic unused_adr;
   assign unused_adr = ^adr_i;
   assign oor        = 1'b0;
   assign err_o      = 1'b0;
`endif

   // Data only advances with read/error entries, so the output stage holds its last returned word.
   always_comb begin
      for (int i = 0; i < LATENCY; i++) pipe_d[i] = pipe_q[i];
      if (!cyc_i) begin
         for (int i = 0; i < LATENCY; i++) pipe_d[i].valid = 1'b0;
      end else begin
         pipe_d[0].valid  = stb_i;
         pipe_d[0].is_err = oor;
         pipe_d[0].is_rd  = ~we_i;
         if (stb_i && oor)
            pipe_d[0].data = '0;
         else if (stb_i && !we_i)
            pipe_d[0].data = mem_q[idx];
         for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i].valid  = pipe_q[i-1].valid;
            pipe_d[i].is_err = pipe_q[i-1].is_err;
            pipe_d[i].is_rd  = pipe_q[i-1].is_rd;
            if (pipe_q[i-1].valid && (pipe_q[i-1].is_rd || pipe_q[i-1].is_err))
               pipe_d[i].data = pipe_q[i-1].data;
         end
      end
   end

   // NOTE: the storage array has no reset branch so it maps onto block RAM; rst only gates writes.
   always_ff @(posedge clk_i) begin
      if (!rst_i && accept && we_i && !oor) begin
         for (int b = 0; b < NB; b++)
            if (sel_i[b]) mem_q[idx][8*b +: 8] <= dat_i[8*b +: 8];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
      end else begin
         for (int i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
      end
   end

   assign ack_o = pipe_q[LAST].valid & ~pipe_q[LAST].is_err;
   assign dat_o = pipe_q[LAST].data;

endmodule
